heater_mode_ctrl: RTL



---
 rtl/heater_pkg.sv | 30 +++
 rtl/heater_timer.sv | 39 +++
 rtl/heater_mode_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/heater_pkg.sv
// rtl/heater_pkg.sv - mode, key-index and heat-level constants shared by the heater sequencer
package heater_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_OFF  = 3'd0;
  localparam mode_t MODE_VENT = 3'd1;
  localparam mode_t MODE_HLO  = 3'd2;
  localparam mode_t MODE_HHI  = 3'd3;
  localparam mode_t MODE_DRY  = 3'd4;
  localparam mode_t MODE_COOL = 3'd5;

  localparam int KEY_OFF   = 0;
  localparam int KEY_LIGHT = 1;
  localparam int KEY_VENT  = 2;
  localparam int KEY_HLO   = 3;
  localparam int KEY_HHI   = 4;
  localparam int KEY_TPLUS = 5;
  localparam int KEY_TCLR  = 6;
  localparam int KEY_DRY   = 7;

  localparam logic [1:0] HEAT_NONE = 2'd0;
  localparam logic [1:0] HEAT_LOW  = 2'd1;
  localparam logic [1:0] HEAT_HIGH = 2'd2;

  function automatic logic is_heat_mode(input mode_t m);
    return (m == MODE_HLO) || (m == MODE_HHI) || (m == MODE_DRY);
  endfunction

endpackage

// File: rtl/heater_timer.sv
// rtl/heater_timer.sv - saturating seconds counter with load/add/clear/decrement and zero-crossing pulse
module heater_timer #(
  parameter int TW     = 12,
  parameter int STEP_S = 300,
  parameter int MAX_S  = 3600
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          add,
  input  logic          dec,
  output logic [TW-1:0] count,
  output logic          expire
);

  logic [TW-1:0] base;
  logic [TW:0]   sum;

  // An add in the same cycle as a load stacks on top of the loaded value.
  assign base   = load ? load_val : count;
  assign sum    = {1'b0, base} + (TW+1)'(STEP_S);
  assign expire = dec && (count == TW'(1));

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (add)
      count <= (sum > (TW+1)'(MAX_S)) ? TW'(MAX_S) : sum[TW-1:0];
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - TW'(1);
  end

endmodule

// File: rtl/heater_mode_ctrl.sv
// rtl/heater_mode_ctrl.sv - bath heater mode sequencer with countdown and forced cool-down
// Optional expiry alarm enabled by defining HEATER_ALARM_EN.
module heater_mode_ctrl
  import heater_pkg::*;
#(
  parameter int DEF_MIN  = 15,
  parameter int MAX_MIN  = 60,
  parameter int STEP_MIN = 5,
  parameter int COOL_S   = 30,
  parameter int TW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_1hz,
  input  logic [7:0]    key,
  output logic [2:0]    mode,
  output logic          light_on,
  output logic          vent_on,
  output logic [1:0]    heat_lvl,
  output logic [TW-1:0] remain_s,
  output logic          alarm
);

  localparam logic [TW-1:0] DEF_LD  = TW'(DEF_MIN * 60);
  localparam logic [TW-1:0] COOL_LD = TW'(COOL_S);

  mode_t         mode_n;
  logic          any_key;
  logic          mk_off;
  logic          mk_sel;
  mode_t         mk_tgt;
  logic          t_clr;
  logic          t_load;
  logic [TW-1:0] t_load_val;
  logic          t_add;
  logic          t_dec;
  logic          t_expire;

  assign any_key = |key;
  // Any key pulse, even the light key, swallows a coincident tick.
  assign t_dec   = tick_1hz && !any_key && (mode != MODE_OFF);

  heater_timer #(
    .TW     (TW),
    .STEP_S (STEP_MIN * 60),
    .MAX_S  (MAX_MIN * 60)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (t_clr),
    .load     (t_load),
    .load_val (t_load_val),
    .add      (t_add),
    .dec      (t_dec),
    .count    (remain_s),
    .expire   (t_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= MODE_OFF;
      light_on <= 1'b0;
    end else begin
      mode <= mode_n;
      if (key[KEY_LIGHT])
        light_on <= !light_on;
    end
  end

  always_comb begin
    mk_off = 1'b0;
    mk_sel = 1'b1;
    mk_tgt = MODE_OFF;
    if (key[KEY_OFF]) begin
      mk_off = 1'b1;
      mk_sel = 1'b0;
    end else if (key[KEY_VENT])
      mk_tgt = MODE_VENT;
    else if (key[KEY_HLO])
      mk_tgt = MODE_HLO;
    else if (key[KEY_HHI])
      mk_tgt = MODE_HHI;
    else if (key[KEY_DRY])
      mk_tgt = MODE_DRY;
    else
      mk_sel = 1'b0;
  end

  always_comb begin
    mode_n     = mode;
    t_clr      = 1'b0;
    t_load     = 1'b0;
    t_load_val = '0;
    t_add      = 1'b0;

    if (mk_off || (mk_sel && (mk_tgt == mode))) begin
      if (is_heat_mode(mode)) begin
        mode_n     = MODE_COOL;
        t_load     = 1'b1;
        t_load_val = COOL_LD;
      end else if (mode == MODE_VENT) begin
        mode_n = MODE_OFF;
        t_load = 1'b1;
      end
    end else if (mk_sel) begin
      mode_n = mk_tgt;
      if (remain_s == '0) begin
        t_load     = 1'b1;
        t_load_val = DEF_LD;
      end
    end

    // Timer keys act on the mode the mode key just selected; a clear while running is an expiry.
    if (mode_n != MODE_COOL) begin
      if (key[KEY_TCLR]) begin
        if (is_heat_mode(mode_n)) begin
          mode_n     = MODE_COOL;
          t_load     = 1'b1;
          t_load_val = COOL_LD;
        end else begin
          mode_n = MODE_OFF;
          t_clr  = 1'b1;
        end
      end else if (key[KEY_TPLUS]) begin
        t_add = 1'b1;
      end
    end

    if (t_expire) begin
      if (is_heat_mode(mode)) begin
        mode_n     = MODE_COOL;
        t_load     = 1'b1;
        t_load_val = COOL_LD;
      end else begin
        mode_n = MODE_OFF;
      end
    end
  end

  always_comb begin
    vent_on  = 1'b0;
    heat_lvl = HEAT_NONE;
    case (mode)
      MODE_VENT, MODE_COOL: vent_on = 1'b1;
      MODE_HLO, MODE_DRY: begin
        vent_on  = 1'b1;
        heat_lvl = HEAT_LOW;
      end
      MODE_HHI: begin
        vent_on  = 1'b1;
        heat_lvl = HEAT_HIGH;
      end
      default: ;
    endcase
  end

`ifdef HEATER_ALARM_EN
  logic [1:0] alarm_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      alarm_cnt <= 2'd0;
    else if (any_key)
      alarm_cnt <= 2'd0;
    else if (t_expire)
      alarm_cnt <= 2'd3;
    else if (tick_1hz && (alarm_cnt != 2'd0))
      alarm_cnt <= alarm_cnt - 2'd1;
  end

  assign alarm = (alarm_cnt != 2'd0);
`else
  assign alarm = 1'b0;
`endif

endmodule
